// File: rtl/lbp_win_ctrl.sv
// 3x3 sliding-window fetch controller for an LBP engine: it walks the interior
// pixel centres row-major and delivers each window through a valid/ready handshake.
module lbp_win_ctrl #(
    parameter int IMG_W = 128,
    parameter int AW    = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          gray_ready,
    input  logic [7:0]    gray_data,
    output logic          gray_req,
    output logic [AW-1:0] gray_addr,
    output logic          win_valid,
    input  logic          win_ready,
    output logic [AW-1:0] win_addr,
    output logic [71:0]   win_data,
    output logic          finish
);

    localparam int CW = AW / 2;
    localparam logic [CW-1:0] LAST = CW'(IMG_W - 2);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        SHIFT = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] row_q, row_d, col_q, col_d;
    logic [1:0]    dx_q, dx_d, dy_q, dy_d;
    logic [71:0]   win_q, win_d;
    logic [3:0]    k_s;
    logic [CW-1:0] r_s, c_s;

    // Byte slot of the pixel being fetched, and its image coordinates.
    assign k_s = {1'b0, dy_q, 1'b0} + {2'b00, dy_q} + {2'b00, dx_q};
    assign r_s = row_q + {{(CW-2){1'b0}}, dy_q} - ONE;
    assign c_s = col_q + {{(CW-2){1'b0}}, dx_q} - ONE;

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            row_q   <= ONE;
            col_q   <= ONE;
            dx_q    <= 2'd0;
            dy_q    <= 2'd0;
            win_q   <= 72'd0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            win_q   <= win_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (gray_ready) state_d = FILL; else state_d = IDLE;
            FILL:  if (gray_ready && dx_q == 2'd2 && dy_q == 2'd2) state_d = EMIT;
                   else state_d = FILL;
            SHIFT: if (gray_ready && dy_q == 2'd2) state_d = EMIT; else state_d = SHIFT;
            EMIT: begin
                if (!win_ready)        state_d = EMIT;
                else if (col_q < LAST) state_d = SHIFT;
                else if (row_q < LAST) state_d = FILL;
                else                   state_d = DONE;
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Counter and window-register updates.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        dx_d  = dx_q;
        dy_d  = dy_q;
        win_d = win_q;
        case (state_q)
            IDLE: begin
                row_d = ONE;
                col_d = ONE;
                dx_d  = 2'd0;
                dy_d  = 2'd0;
            end
            FILL: begin
                if (gray_ready) begin
                    win_d[{k_s, 3'b000} +: 8] = gray_data;
                    dy_d = (dy_q == 2'd2) ? 2'd0 : dy_q + 2'd1;
                    dx_d = (dy_q == 2'd2 && dx_q != 2'd2) ? dx_q + 2'd1 : dx_q;
                end else begin
                    dy_d = dy_q;
                end
            end
            SHIFT: begin
                if (gray_ready) begin
                    win_d[{k_s, 3'b000} +: 8] = gray_data;
                    dy_d = (dy_q == 2'd2) ? 2'd0 : dy_q + 2'd1;
                end else begin
                    dy_d = dy_q;
                end
            end
            EMIT: begin
                if (win_ready && col_q < LAST) begin
                    // Slide left on the handshake edge so SHIFT only refills dx=2.
                    col_d = col_q + ONE;
                    dx_d  = 2'd2;
                    dy_d  = 2'd0;
                    for (int i = 0; i < 3; i++) begin
                        win_d[24*i +: 8]     = win_q[24*i + 8 +: 8];
                        win_d[24*i + 8 +: 8] = win_q[24*i + 16 +: 8];
                    end
                end else if (win_ready && row_q < LAST) begin
                    row_d = row_q + ONE;
                    col_d = ONE;
                    dx_d  = 2'd0;
                    dy_d  = 2'd0;
                end else begin
                    row_d = row_q;
                end
            end
            default: row_d = row_q;
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        gray_req  = 1'b0;
        win_valid = 1'b0;
        finish    = 1'b0;
        case (state_q)
            FILL, SHIFT: gray_req  = gray_ready;
            EMIT:        win_valid = 1'b1;
            DONE:        finish    = 1'b1;
            default:     gray_req  = 1'b0;
        endcase
        gray_addr = {r_s, c_s};
        win_addr  = win_valid ? {row_q, col_q} : {AW{1'b0}};
        win_data  = win_q;
    end

endmodule

// File: tb/tb_lbp_win_ctrl.sv
// Directed self-checking bench for lbp_win_ctrl at the default 128x128 size.
module tb_lbp_win_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        gray_ready;
    logic [7:0]  gray_data;
    logic        gray_req;
    logic [13:0] gray_addr;
    logic        win_valid;
    logic        win_ready;
    logic [13:0] win_addr;
    logic [71:0] win_data;
    logic        finish;

    int checks = 0;
    int errors = 0;

    lbp_win_ctrl dut (
        .clk(clk), .reset(reset), .gray_ready(gray_ready), .gray_data(gray_data),
        .gray_req(gray_req), .gray_addr(gray_addr), .win_valid(win_valid),
        .win_ready(win_ready), .win_addr(win_addr), .win_data(win_data), .finish(finish)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input int addr);
        logic [13:0] a;
        a = addr[13:0];
        return a[7:0] ^ {1'b0, a[13:7]};
    endfunction

    assign gray_data = pix(int'(gray_addr));

    function automatic logic [71:0] exp_win(input int r, input int c);
        logic [71:0] w;
        w = 72'd0;
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++)
                w[8*(3*dy+dx) +: 8] = pix((r - 1 + dy) * 128 + c - 1 + dx);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_req"},   {71'd0, gray_req},  72'd0);
        chk({tag, "_gaddr"}, {58'd0, gray_addr}, 72'd0);
        chk({tag, "_valid"}, {71'd0, win_valid}, 72'd0);
        chk({tag, "_waddr"}, {58'd0, win_addr},  72'd0);
        chk({tag, "_wdata"}, win_data,           72'd0);
        chk({tag, "_finish"},{71'd0, finish},    72'd0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int fill_addr [9] = '{0, 128, 256, 1, 129, 257, 2, 130, 258};

    initial begin
        int r, c, nf, ncyc, exp_n, hs, exp_a;
        logic done, abort;

        reset = 1'b1; gray_ready = 1'b0; win_ready = 1'b0;
        repeat (3) cyc();
        chk_zero_outputs("reset");

        // Stays idle without gray_ready.
        reset = 1'b0;
        repeat (3) begin
            cyc();
            chk("idle_hold", {70'd0, gray_req, win_valid}, 72'd0);
        end

        // First FILL with a 5-cycle gray_ready pause after four fetches.
        gray_ready = 1'b1;
        cyc();
        for (int i = 0; i < 9; i++) begin
            if (i == 4) begin
                gray_ready = 1'b0;
                for (int p = 0; p < 5; p++) begin
                    #1 chk("pause_req", {71'd0, gray_req}, 72'd0);
                    cyc();
                end
                gray_ready = 1'b1;
            end
            #1;
            chk("fill_req", {71'd0, gray_req}, 72'd1);
            chk("fill_addr", {58'd0, gray_addr}, 72'(fill_addr[i]));
            cyc();
        end

        // Window 129 held by win_ready=0 for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            chk("hold_valid", {71'd0, win_valid}, 72'd1);
            chk("hold_addr", {58'd0, win_addr}, 72'd129);
            chk("hold_data", win_data, exp_win(1, 1));
            chk("hold_req", {71'd0, gray_req}, 72'd0);
            cyc();
        end

        // Release: only column col+1 is fetched for the next window.
        win_ready = 1'b1;
        cyc();
        win_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("shift_req", {71'd0, gray_req}, 72'd1);
            chk("shift_addr", {58'd0, gray_addr}, 72'(3 + 128 * i));
            cyc();
        end
        chk("win2_valid", {71'd0, win_valid}, 72'd1);
        chk("win2_addr", {58'd0, win_addr}, 72'd130);
        chk("win2_data", win_data, exp_win(1, 2));

        // Asynchronous reset in the middle of EMIT.
        #2 reset = 1'b1;
        #1;
        chk_zero_outputs("async_rst");
        cyc();
        gray_ready = 1'b0;
        reset = 1'b0;
        cyc();
        chk("post_rst_idle", {70'd0, gray_req, win_valid}, 72'd0);

        // Minimum-latency restart, then the whole image with win_ready high.
        gray_ready = 1'b1;
        win_ready = 1'b1;
        cyc();
        for (int i = 0; i < 9; i++) begin
            chk("re_fill_req", {71'd0, gray_req}, 72'd1);
            chk("re_fill_addr", {58'd0, gray_addr}, 72'(fill_addr[i]));
            cyc();
        end
        chk("latency10", {71'd0, win_valid}, 72'd1);

        r = 1; c = 1; hs = 0; done = 1'b0; abort = 1'b0;
        while (!done && !abort) begin
            chk("scan_addr", {58'd0, win_addr}, 72'(r * 128 + c));
            chk("scan_data", win_data, exp_win(r, c));
            cyc();
            hs++;
            if (c < 126) begin
                c++; exp_n = 3;
            end else if (r < 126) begin
                r++; c = 1; exp_n = 9;
            end else begin
                done = 1'b1; exp_n = 0;
            end
            if (!done) begin
                nf = 0; ncyc = 0;
                while (!win_valid && ncyc < 20) begin
                    if (gray_req) begin
                        if (exp_n == 3) exp_a = (r - 1 + nf) * 128 + c + 1;
                        else exp_a = (r - 1 + nf % 3) * 128 + c - 1 + nf / 3;
                        chk("scan_fetch", {58'd0, gray_addr}, 72'(exp_a));
                        nf++;
                    end
                    cyc();
                    ncyc++;
                end
                chk("scan_nfetch", 72'(nf), 72'(exp_n));
                chk("scan_latency", 72'(ncyc), 72'(exp_n));
                if (!win_valid) abort = 1'b1;
            end
        end
        chk("handshakes", 72'(hs), 72'd15876);

        // DONE holds and ignores gray_ready.
        for (int i = 0; i < 6; i++) begin
            gray_ready = i[0];
            #1;
            chk("done_finish", {71'd0, finish}, 72'd1);
            chk("done_quiet", {70'd0, gray_req, win_valid}, 72'd0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
